arm_reg_file: RTL

- Banked ARM7 register file: the responder side of the single-port register read/write request interface that execution units (branch, data-processing, load/store) drive.
- Holds R0–R15 with ARM mode banking, the CPSR and the five SPSRs.
- Services one registered read and one write per cycle.
- Performs CPSR restore from SPSR and exception-entry register updates.
- Exports PC and CPSR to fetch/decode.

---
 rtl/arm_reg_file.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/arm_reg_file.sv
// Banked ARM7 register file: R0-R15 with mode banking, CPSR and five SPSRs.
// One registered read and one write per cycle, plus SPSR restore and exception entry.
module arm_reg_file #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_en,
    input  logic [3:0]  read_reg,
    output logic [31:0] read_value,
    input  logic        write_en,
    input  logic [3:0]  write_reg,
    input  logic [31:0] write_value,
    input  logic        write_restore_from_SPSR,
    input  logic        cpsr_we,
    input  logic [31:0] cpsr_wdata,
    input  logic        spsr_we,
    input  logic [31:0] spsr_wdata,
    input  logic        exc_en,
    input  logic [4:0]  exc_mode,
    input  logic [31:0] exc_return,
    input  logic [31:0] exc_vector,
    output logic [31:0] pc,
    output logic [31:0] cpsr,
    output logic [31:0] spsr
);

    typedef enum logic [2:0] {
        BANK_USR = 3'd0,
        BANK_FIQ = 3'd1,
        BANK_IRQ = 3'd2,
        BANK_SVC = 3'd3,
        BANK_ABT = 3'd4,
        BANK_UND = 3'd5
    } bank_e;

    logic [31:0] usr_r  [0:12];
    logic [31:0] fiq_hi [8:12];
    logic [31:0] sp_b   [0:5];
    logic [31:0] lr_b   [0:5];
    logic [31:0] spsr_b [0:5];
    logic [31:0] pc_q;
    logic [31:0] cpsr_q;

    bank_e cur_bank;
    bank_e exc_bank;
    logic  exc_take;
    logic  restore_req;

    // SYS and every unrecognised encoding share the user bank and have no SPSR.
    function automatic bank_e bank_of(input logic [4:0] mode);
        case (mode)
            5'b10001: bank_of = BANK_FIQ;
            5'b10010: bank_of = BANK_IRQ;
            5'b10011: bank_of = BANK_SVC;
            5'b10111: bank_of = BANK_ABT;
            5'b11011: bank_of = BANK_UND;
            default:  bank_of = BANK_USR;
        endcase
    endfunction

    function automatic logic [31:0] rd_reg(input bank_e b, input logic [3:0] idx);
        case (idx)
            4'd15:                         rd_reg = pc_q;
            4'd14:                         rd_reg = lr_b[b];
            4'd13:                         rd_reg = sp_b[b];
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                rd_reg = (b == BANK_FIQ) ? fiq_hi[idx] : usr_r[idx];
            default:                       rd_reg = usr_r[idx];
        endcase
    endfunction

    assign cur_bank    = bank_of(cpsr_q[4:0]);
    assign exc_bank    = bank_of(exc_mode);
    assign exc_take    = exc_en && (exc_bank != BANK_USR);
    assign restore_req = write_en && write_restore_from_SPSR;

    assign pc   = pc_q;
    assign cpsr = cpsr_q;
    assign spsr = (cur_bank == BANK_USR) ? 32'h0 : spsr_b[cur_bank];

    // Exception entry pre-empts every other update; otherwise write, CPSR and SPSR updates
    // all use the bank of the mode in force before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 13; i++) usr_r[i] <= '0;
            for (int i = 8; i < 13; i++) fiq_hi[i] <= '0;
            for (int i = 0; i < 6; i++) begin
                sp_b[i]   <= '0;
                lr_b[i]   <= '0;
                spsr_b[i] <= '0;
            end
            pc_q   <= RESET_PC;
            cpsr_q <= RESET_CPSR;
        end else if (exc_take) begin
            spsr_b[exc_bank] <= cpsr_q;
            lr_b[exc_bank]   <= exc_return;
            pc_q             <= exc_vector;
            cpsr_q           <= {cpsr_q[31:8], 1'b1,
                                 (exc_bank == BANK_FIQ) ? 1'b1 : cpsr_q[6],
                                 1'b0, exc_mode};
        end else begin
            if (write_en) begin
                case (write_reg)
                    4'd15: pc_q <= write_value;
                    4'd14: lr_b[cur_bank] <= write_value;
                    4'd13: sp_b[cur_bank] <= write_value;
                    4'd8, 4'd9, 4'd10, 4'd11, 4'd12: begin
                        if (cur_bank == BANK_FIQ)
                            fiq_hi[write_reg] <= write_value;
                        else
                            usr_r[write_reg] <= write_value;
                    end
                    default: usr_r[write_reg] <= write_value;
                endcase
            end
            if (restore_req) begin
                if (cur_bank != BANK_USR)
                    cpsr_q <= spsr_b[cur_bank];
            end else if (cpsr_we) begin
                cpsr_q <= cpsr_wdata;
            end
            if (spsr_we && (cur_bank != BANK_USR))
                spsr_b[cur_bank] <= spsr_wdata;
        end
    end

    // Same-register write bypasses into the read, except when an exception drops the write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_value <= '0;
        end else if (read_en) begin
            if (!exc_take && write_en && (write_reg == read_reg))
                read_value <= write_value;
            else
                read_value <= rd_reg(cur_bank, read_reg);
        end
    end

endmodule
